irsender_wb8: RTL and testbench
===============================

Name: irsender_wb8

Overview:
- Wishbone-8 peripheral that transmits NEC-format infrared frames.
- It is the transmit-side counterpart of irdecoder_wb8 and sits in the reserved 0xFFFFFAxx I/O window.
- The CPU loads an address byte and a command byte, then triggers a full frame or a repeat code.
- The block generates the leader, the 32 pulse-distance-coded bits and the stop burst, modulated onto a 38 kHz carrier, for an IR LED driver.

Parameters:
CLOCKFREQ, 25125000, bus clock in Hz; sets all timing.
CARRIERFREQ, 38000, carrier frequency in Hz.
Derived localparams (integer truncation):
- UNIT = CLOCKFREQ*9/16000 cycles (562.5 us); 14132 at default.
- CHALF = CLOCKFREQ/(2*CARRIERFREQ) cycles; 330 at default.
- Both must be ≥1.

Ports:
I_wb_clk  in  1  bus clock, the only clock.
I_reset  in  1  synchronous, active-high reset.
I_wb_adr  in  2  register select.
I_wb_dat  in  8  write data.
I_wb_stb  in  1  strobe.
I_wb_we  in  1  write enable.
O_wb_dat  out  8  read data.
O_wb_ack  out  1  acknowledge.
O_busy  out  1  high while a transmission is in progress.
O_ir_signal  out  1  modulated IR output, registered.

Behaviour:
- Registers:
  - adr0: ADDR (r/w).
  - adr1: CMD (r/w).
  - adr2 write: bit0 = send frame, bit1 = send repeat, bit7 = INVERT.
  - adr2 read: {INVERT, 6'b0, busy}.
  - adr3: reads 0, writes ignored.
- Reset: ADDR = 0, CMD = 0, INVERT = 0, state IDLE, O_busy = 0, O_ir_signal = 0, O_wb_ack = 0.
- Reset asserted mid-transmission aborts immediately; O_ir_signal is 0 on the next edge.
- Ack: O_wb_ack is registered I_wb_stb, i.e. asserted the cycle after every strobe cycle, for reads and writes.
- O_wb_dat is registered on the strobe cycle.
- ADDR and CMD may be written while busy. They are copied into a 32-bit shift register only at frame start, so they affect the next frame only.
- Start trigger: a write to adr2 with bit0 or bit1 set while IDLE.
  - On that same clock edge: busy = 1, state = LEAD_MARK, carrier phase = high.
  - O_ir_signal is high from that edge when INVERT = 0.
  - If bit0 and bit1 are set together, the full frame wins.
  - Triggers while busy are ignored; the INVERT bit still updates.
- Frame payload: {~CMD, CMD, ~ADDR, ADDR}, sent LSB first (ADDR bit0 first).
- FSM states and durations (1 unit = UNIT cycles):
  - IDLE.
  - LEAD_MARK: 16 units.
  - LEAD_SPACE: 8 units for a frame, 4 units for a repeat.
  - BIT_MARK: 1 unit.
  - BIT_SPACE: 1 unit for a 0 bit, 3 units for a 1 bit.
  - STOP_MARK: 1 unit.
- Transitions:
  - Frame: LEAD_MARK → LEAD_SPACE → (BIT_MARK → BIT_SPACE) ×32 → STOP_MARK → IDLE.
  - Repeat: LEAD_MARK → LEAD_SPACE → STOP_MARK → IDLE.
  - The bit index counts 0..31; the shift register shifts right after each BIT_SPACE.
- Every frame contains exactly 16 ones and 16 zeros, so a frame lasts 121 units and a repeat lasts 21 units, with no gaps between states.
- busy falls on the edge that enters IDLE.
- Mark modulation:
  - The carrier toggles every CHALF cycles.
  - Its phase restarts high at the start of each mark state.
  - The last partial half-period is truncated at the mark end.
- In space and IDLE the raw signal is 0.
- O_ir_signal = raw ^ INVERT; INVERT takes effect on the next edge, including in IDLE.
- Timing counters: a unit prescaler 0..UNIT-1 plus a units-remaining counter; neither wraps beyond its terminal count.

Test Plan (CLOCKFREQ=160000 → UNIT=90, CHALF=2 unless stated):
1. Reset → O_ir_signal = 0, O_busy = 0. Reads of adr0/1/2/3 return 0x00, each acked exactly one cycle after stb.
2. ADDR=0x00, CMD=0xFF, write 0x01 to adr2:
   - busy high for 121×90 = 10890 cycles.
   - Leader mark 1440 cycles, carrier toggling every 2 cycles starting high, then 720 low cycles.
   - Decoded bits: 8×0, 8×1, 8×1, 8×0.
3. Write 0x02 to adr2 → busy 21×90 = 1890 cycles; marks of 1440 and 90 cycles, space 360.
4. During a frame: write ADDR=0x55 and retrigger 0x01 → current frame unchanged, no second frame. The next trigger sends 0x55, 0xAA.
5. Write 0x80 while IDLE → O_ir_signal = 1 next cycle. A subsequent frame is the exact complement of scenario 2.
6. Assert I_reset at cycle 3000 of a frame → next edge O_ir_signal = 0, O_busy = 0, INVERT = 0. A new trigger then produces a full 10890-cycle frame.
7. Default CLOCKFREQ → leader mark = 226112 cycles (16×14132), carrier half-period 330 cycles.

Source files
------------

// File: rtl/irsender_wb8.sv
// irsender_wb8: Wishbone-8 NEC infrared frame transmitter with a 38 kHz carrier.
// Ports:
//   I_wb_clk     bus clock, the only clock
//   I_reset      synchronous active-high reset
//   I_wb_adr     register select (0 ADDR, 1 CMD, 2 control/status, 3 reserved)
//   I_wb_dat     write data
//   I_wb_stb     strobe
//   I_wb_we      write enable
//   O_wb_dat     registered read data
//   O_wb_ack     registered acknowledge, one cycle after every strobe cycle
//   O_busy       high while a frame or repeat code is being sent
//   O_ir_signal  registered, carrier-modulated IR output (optionally inverted)
module irsender_wb8 #(
    parameter int unsigned CLOCKFREQ   = 25125000,
    parameter int unsigned CARRIERFREQ = 38000
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [1:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic [7:0] O_wb_dat,
    output logic       O_wb_ack,
    output logic       O_busy,
    output logic       O_ir_signal
);

    localparam int unsigned UNIT    = CLOCKFREQ * 9 / 16000;
    localparam int unsigned CHALF   = CLOCKFREQ / (2 * CARRIERFREQ);
    localparam int unsigned PRE_W   = (UNIT > 1) ? $clog2(UNIT) : 1;
    localparam int unsigned CAR_W   = (CHALF > 1) ? $clog2(CHALF) : 1;
    localparam int unsigned UNITS_W = 5;
    localparam int unsigned BIT_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_e;

    state_e               state_q, state_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [UNITS_W-1:0]   units_q, units_d;
    logic [CAR_W-1:0]     car_cnt_q, car_cnt_d;
    logic                 car_q, car_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [31:0]          shreg_q, shreg_d;
    logic                 rep_q, rep_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           cmd_q, cmd_d;
    logic                 inv_q, inv_d;
    logic [7:0]           dat_q, dat_d;
    logic                 ir_q, ir_d;
    logic                 busy_q, busy_d;
    logic                 ack_q;
    logic                 mark_d;

    logic wr, trig, unit_end, seg_end;

    assign wr       = I_wb_stb && I_wb_we;
    assign trig     = wr && (I_wb_adr == 2'd2) && (I_wb_dat[0] || I_wb_dat[1]);
    assign unit_end = (pre_q == PRE_W'(UNIT - 1));
    assign seg_end  = unit_end && (units_q == UNITS_W'(1));

    // State and datapath registers
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            units_q   <= '0;
            car_cnt_q <= '0;
            car_q     <= 1'b0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            rep_q     <= 1'b0;
            addr_q    <= '0;
            cmd_q     <= '0;
            inv_q     <= 1'b0;
            dat_q     <= '0;
            ir_q      <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            units_q   <= units_d;
            car_cnt_q <= car_cnt_d;
            car_q     <= car_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            rep_q     <= rep_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            inv_q     <= inv_d;
            dat_q     <= dat_d;
            ir_q      <= ir_d;
            busy_q    <= busy_d;
            ack_q     <= I_wb_stb;
        end
    end

    // Bus registers, sequencer and carrier next-state
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        units_d   = units_q;
        car_cnt_d = car_cnt_q;
        car_d     = car_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        rep_d     = rep_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        inv_d     = inv_q;
        dat_d     = dat_q;
        mark_d    = 1'b0;
        ir_d      = 1'b0;
        busy_d    = 1'b0;

        if (wr) begin
            case (I_wb_adr)
                2'd0:    addr_d = I_wb_dat;
                2'd1:    cmd_d  = I_wb_dat;
                2'd2:    inv_d  = I_wb_dat[7];
                default: ;
            endcase
        end

        if (I_wb_stb && !I_wb_we) begin
            case (I_wb_adr)
                2'd0:    dat_d = addr_q;
                2'd1:    dat_d = cmd_q;
                2'd2:    dat_d = {inv_q, 6'b0, busy_q};
                default: dat_d = 8'h00;
            endcase
        end

        if (state_q == IDLE) begin
            if (trig) begin
                state_d   = LEAD_MARK;
                units_d   = UNITS_W'(16);
                pre_d     = '0;
                rep_d     = !I_wb_dat[0];
                bit_idx_d = '0;
                shreg_d   = {~cmd_q, cmd_q, ~addr_q, addr_q};
            end
        end else begin
            pre_d = unit_end ? '0 : pre_q + PRE_W'(1);
            if (unit_end) begin
                units_d = units_q - UNITS_W'(1);
            end
            if (seg_end) begin
                units_d = UNITS_W'(1);
                case (state_q)
                    LEAD_MARK: begin
                        state_d = LEAD_SPACE;
                        units_d = rep_q ? UNITS_W'(4) : UNITS_W'(8);
                    end
                    LEAD_SPACE: state_d = rep_q ? STOP_MARK : BIT_MARK;
                    BIT_MARK: begin
                        state_d = BIT_SPACE;
                        units_d = shreg_q[0] ? UNITS_W'(3) : UNITS_W'(1);
                    end
                    BIT_SPACE: begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        state_d   = (bit_idx_q == BIT_W'(31)) ? STOP_MARK : BIT_MARK;
                    end
                    default: begin
                        state_d = IDLE;
                        units_d = '0;
                    end
                endcase
            end
        end

        mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

        // Carrier phase restarts high on every state change; free-runs only inside a mark
        if (state_d != state_q) begin
            car_d     = 1'b1;
            car_cnt_d = '0;
        end else if (mark_d) begin
            if (car_cnt_q == CAR_W'(CHALF - 1)) begin
                car_cnt_d = '0;
                car_d     = ~car_q;
            end else begin
                car_cnt_d = car_cnt_q + CAR_W'(1);
            end
        end

        ir_d   = (mark_d && car_d) ^ inv_d;
        busy_d = (state_d != IDLE);
    end

    assign O_wb_dat    = dat_q;
    assign O_wb_ack    = ack_q;
    assign O_busy      = busy_q;
    assign O_ir_signal = ir_q;

endmodule

// File: tb/tb_irsender_wb8.sv
// tb_irsender_wb8: self-checking bench for irsender_wb8 at CLOCKFREQ=160000 (UNIT=90, CHALF=2).
module tb_irsender_wb8;

    localparam int unsigned CF    = 160000;
    localparam int unsigned CR    = 38000;
    localparam int unsigned UNIT  = CF * 9 / 16000;
    localparam int unsigned CHALF = CF / (2 * CR);

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] adr;
    logic [7:0] dat_w;
    logic       stb;
    logic       we;
    logic [7:0] dat_r;
    logic       ack;
    logic       busy;
    logic       ir;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    irsender_wb8 #(.CLOCKFREQ(CF), .CARRIERFREQ(CR)) dut (
        .I_wb_clk    (clk),
        .I_reset     (rst),
        .I_wb_adr    (adr),
        .I_wb_dat    (dat_w),
        .I_wb_stb    (stb),
        .I_wb_we     (we),
        .O_wb_dat    (dat_r),
        .O_wb_ack    (ack),
        .O_busy      (busy),
        .O_ir_signal (ir)
    );

    always #5 clk = ~clk;

    // Append one mark or space segment of the given length in units to the expected waveform
    task automatic add_seg(input bit mark, input int units, input bit inv);
        for (int k = 0; k < units * int'(UNIT); k++) begin
            exp_q.push_back((mark && ((k / int'(CHALF)) % 2 == 0)) ^ inv);
        end
    endtask

    // Expected per-cycle IR output of a whole NEC frame or repeat code
    task automatic build_exp(input logic [7:0] a, input logic [7:0] c, input bit rep, input bit inv);
        logic [31:0] pl;
        pl = {~c, c, ~a, a};
        exp_q.delete();
        add_seg(1'b1, 16, inv);
        add_seg(1'b0, rep ? 4 : 8, inv);
        if (!rep) begin
            for (int i = 0; i < 32; i++) begin
                add_seg(1'b1, 1, inv);
                add_seg(1'b0, pl[i] ? 3 : 1, inv);
            end
        end
        add_seg(1'b1, 1, inv);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        adr = a; dat_w = d; we = 1'b1; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        n_tests++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ack adr=%0d: got %b want 1", a, ack);
        end
    endtask

    task automatic wb_read(input logic [1:0] a, input logic [7:0] expd, input string nm);
        logic       a0, a1, a2;
        logic [7:0] got;
        @(negedge clk);
        adr = a; we = 1'b0; stb = 1'b1;
        a0 = ack;
        @(negedge clk);
        stb = 1'b0;
        a1 = ack; got = dat_r;
        @(negedge clk);
        a2 = ack;
        n_tests += 2;
        if (got !== expd) begin
            n_fail++;
            $display("FAIL %s data: got %h want %h", nm, got, expd);
        end
        if ({a0, a1, a2} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s ack_seq: got %b want 010", nm, {a0, a1, a2});
        end
    endtask

    // Called on the negedge right after the trigger edge; compares IR and busy every cycle.
    // Optionally writes ADDR=poke_val and a frame retrigger starting at cycle poke_at.
    task automatic check_frame(input logic [7:0] a, input logic [7:0] c, input bit rep,
                               input bit inv, input int poke_at, input logic [7:0] poke_val,
                               input string nm);
        int total;
        bit bad_ir, bad_busy;
        bit e_ir, e_busy;
        build_exp(a, c, rep, inv);
        total    = exp_q.size();
        bad_ir   = 1'b0;
        bad_busy = 1'b0;
        for (int k = 0; k < total + 6; k++) begin
            e_ir   = (k < total) ? exp_q[k] : inv;
            e_busy = (k < total);
            if (ir !== e_ir) begin
                if (!bad_ir) $display("FAIL %s ir cycle %0d: got %b want %b", nm, k, ir, e_ir);
                bad_ir = 1'b1;
            end
            if (busy !== e_busy) begin
                if (!bad_busy) $display("FAIL %s busy cycle %0d: got %b want %b", nm, k, busy, e_busy);
                bad_busy = 1'b1;
            end
            if (poke_at >= 0) begin
                if (k == poke_at) begin
                    adr = 2'd0; dat_w = poke_val; we = 1'b1; stb = 1'b1;
                end else if (k == poke_at + 1) begin
                    adr = 2'd2; dat_w = 8'h01;
                end else if (k == poke_at + 2) begin
                    stb = 1'b0; we = 1'b0;
                end
            end
            @(negedge clk);
        end
        n_tests += 2;
        n_fail  += int'(bad_ir) + int'(bad_busy);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests += 3;
        if (ir !== 1'b0)   begin n_fail++; $display("FAIL reset_ir: got %b want 0", ir); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (ack !== 1'b0)  begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_read(2'(i), 8'h00, "reset_read");
        end
    endtask

    task automatic test_regs();
        logic [7:0] a, c;
        a = 8'($urandom);
        c = 8'($urandom);
        wb_write(2'd0, a);
        wb_write(2'd1, c);
        wb_write(2'd3, 8'($urandom));
        wb_read(2'd0, a, "read_addr");
        wb_read(2'd1, c, "read_cmd");
        wb_read(2'd3, 8'h00, "read_adr3");
        wb_read(2'd2, 8'h00, "read_status");
    endtask

    task automatic test_frame();
        wb_write(2'd0, 8'h00);
        wb_write(2'd1, 8'hFF);
        wb_write(2'd2, 8'h01);
        check_frame(8'h00, 8'hFF, 1'b0, 1'b0, -1, 8'h00, "frame_00_ff");
    endtask

    task automatic test_repeat();
        wb_write(2'd2, 8'h02);
        check_frame(8'h00, 8'hFF, 1'b1, 1'b0, -1, 8'h00, "repeat");
    endtask

    task automatic test_busy_writes();
        logic [7:0] a, c;
        a = 8'($urandom);
        c = 8'($urandom);
        wb_write(2'd0, a);
        wb_write(2'd1, c);
        wb_write(2'd2, 8'h03);
        check_frame(a, c, 1'b0, 1'b0, int'($urandom_range(100, 5000)), 8'h55, "frame_while_poked");
        wb_write(2'd2, 8'h01);
        check_frame(8'h55, c, 1'b0, 1'b0, -1, 8'h00, "frame_after_poke");
    endtask

    task automatic test_invert();
        wb_write(2'd2, 8'h80);
        n_tests++;
        if (ir !== 1'b1) begin n_fail++; $display("FAIL invert_idle: got %b want 1", ir); end
        wb_read(2'd2, 8'h80, "read_invert");
        wb_write(2'd0, 8'h00);
        wb_write(2'd1, 8'hFF);
        wb_write(2'd2, 8'h81);
        check_frame(8'h00, 8'hFF, 1'b0, 1'b1, -1, 8'h00, "frame_inverted");
        wb_write(2'd2, 8'h00);
        n_tests++;
        if (ir !== 1'b0) begin n_fail++; $display("FAIL invert_clear: got %b want 0", ir); end
    endtask

    task automatic test_reset_mid();
        wb_write(2'd2, 8'h81);
        repeat (2999) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests += 2;
        if (ir !== 1'b0)   begin n_fail++; $display("FAIL midreset_ir: got %b want 0", ir); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        rst = 1'b0;
        wb_read(2'd2, 8'h00, "midreset_status");
        wb_write(2'd2, 8'h01);
        check_frame(8'h00, 8'h00, 1'b0, 1'b0, -1, 8'h00, "frame_after_reset");
    endtask

    task automatic test_random_repeats();
        bit inv;
        for (int i = 0; i < 2; i++) begin
            inv = 1'($urandom_range(0, 1));
            wb_write(2'd2, {inv, 7'b0000010});
            check_frame(8'h00, 8'h00, 1'b1, inv, -1, 8'h00, "random_repeat");
        end
    endtask

    initial begin
        rst = 1'b1; adr = '0; dat_w = '0; stb = 1'b0; we = 1'b0;
        test_reset();
        test_regs();
        test_frame();
        test_repeat();
        test_busy_writes();
        test_invert();
        test_reset_mid();
        test_random_repeats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
